seg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment driver that succeeds the fixed 4-digit scan loop in the game top level.
- Takes a packed BCD/hex value, per-digit decimal points and a leading-zero-blank control, and drives active-low segment and anode lines.
- Refresh timing comes from an internal prescaler on the master clock; no derived clock is used.
- Adds frame-coherent input snapshotting, anti-ghosting dead time, leading-zero blanking and optional brightness PWM.

---
 rtl/seg_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: drives active-low segment and anode lines, scanning the MSD first.
// Latency: every output is registered, so the pins follow the prescaler/index state by exactly 1 clk.
// Backpressure: none; inputs are sampled once per frame, and the scan timing runs regardless of blank.
//
// Ports:
//   clk, rst        master clock; synchronous active-low reset
//   value, dp, lzb  packed digit codes (digit 0 in [3:0]), decimal points, leading-zero blank
//   blank           forces all anodes off without disturbing scan timing
//   bright          (only with SEG_SCAN_BRIGHTNESS_EN) 4-bit PWM duty, x/16
//   seg, dp_n, an   active-low segment, decimal point and anode outputs
//   frame_start     one-cycle pulse as the slot for digit NUM_DIGITS-1 begins
// Optional brightness PWM is enabled by defining the macro SEG_SCAN_BRIGHTNESS_EN.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16,
    parameter int HEX_MODE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lzb,
    input  logic                    blank,
`ifdef SEG_SCAN_BRIGHTNESS_EN
    input  logic [3:0]              bright,
`endif
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_DEAD = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_MSD    = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    started;
    logic [4*NUM_DIGITS-1:0] value_s;
    logic [NUM_DIGITS-1:0]   dp_s;
    logic                    lzb_s;

    logic                    presc_last;
    logic                    snap_take;
    logic [PW-1:0]           presc_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [3:0]              code;
    logic                    dp_cur;
    logic [NUM_DIGITS-1:0]   lz_run;
    logic                    zero_run;
    logic                    digit_blanked;
    logic                    an_on;
    logic [6:0]              seg_nxt;
    logic                    dp_n_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        if (HEX_MODE == 0 && c > 4'd9) begin
            s = 7'h7F;
        end
        return s;
    endfunction

    // Snapshot on the first cycle out of reset and whenever the scan wraps back to the MSD.
    always_comb begin
        presc_last = (presc == PRESC_LAST);
        snap_take  = !started || (presc_last && idx == '0);
        presc_nxt  = presc_last ? '0 : presc + 1'b1;
        idx_nxt    = idx;
        if (presc_last) begin
            idx_nxt = (idx == '0) ? IDX_MSD : idx - 1'b1;
        end
    end

`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0] bright_s;
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bright_s <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (snap_take) begin
                bright_s <= bright;
            end
        end
    end

    logic pwm_on;
    assign pwm_on = (pwm_cnt < bright_s);
`else
    logic pwm_on;
    assign pwm_on = 1'b1;
`endif

    // Digit i is a leading zero when it and every digit above it are code 0.
    always_comb begin
        code     = 4'h0;
        dp_cur   = 1'b0;
        zero_run = 1'b1;
        lz_run   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run && (value_s[i*4 +: 4] == 4'h0);
            lz_run[i] = zero_run;
            if (IW'(i) == idx) begin
                code   = value_s[i*4 +: 4];
                dp_cur = dp_s[i];
            end
        end
        digit_blanked = lzb_s && (idx != '0) && lz_run[idx];

        seg_nxt  = 7'h7F;
        dp_n_nxt = 1'b1;
        an_on    = 1'b0;
        if (presc >= PRESC_DEAD) begin
            an_on = !blank && pwm_on;
            if (!digit_blanked) begin
                seg_nxt  = decode(code);
                dp_n_nxt = !dp_cur;
            end
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt[i] = !(an_on && (IW'(i) == idx));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc       <= '0;
            idx         <= IDX_MSD;
            started     <= 1'b0;
            value_s     <= '0;
            dp_s        <= '0;
            lzb_s       <= 1'b0;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            presc       <= presc_nxt;
            idx         <= idx_nxt;
            started     <= 1'b1;
            seg         <= seg_nxt;
            dp_n        <= dp_n_nxt;
            an          <= an_nxt;
            frame_start <= snap_take;
            if (snap_take) begin
                value_s <= value;
                dp_s    <= dp;
                lzb_s   <= lzb;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DC = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
    logic        blank;
    logic [6:0]  seg, seg_h0;
    logic        dp_n, dp_n_h0;
    logic [3:0]  an, an_h0;
    logic        frame_start, fs_h0;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .HEX_MODE(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .lzb(lzb), .blank(blank),
        .seg(seg), .dp_n(dp_n), .an(an), .frame_start(frame_start)
    );

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .HEX_MODE(0)) dut_h0 (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .lzb(lzb), .blank(blank),
        .seg(seg_h0), .dp_n(dp_n_h0), .an(an_h0), .frame_start(fs_h0)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: edges since reset release, plus the per-frame input snapshot.
    int          m = 0;
    logic [15:0] snap_val = '0;
    logic [3:0]  snap_dp  = '0;
    logic        snap_lzb = 1'b0;

    logic [6:0] exp_seg, exp_seg_h0;
    logic       exp_dp_n, exp_fs;
    logic [3:0] exp_an;

    function automatic logic [6:0] dec(input logic [3:0] c, input bit hex);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (!hex && c > 4'd9) return 7'h7F;
        return tbl[c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s at m=%0d: observed=%h expected=%h", tag, m, obs, exp_v);
        end
    endtask

    // One clock: predict outputs from what the DUT sees at the edge, then check on the falling edge.
    task automatic tick();
        int n, presc, d;
        bit dark;
        @(posedge clk);
        if (!rst) begin
            m = 0;
            snap_val = '0; snap_dp = '0; snap_lzb = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_seg_h0 = 7'h7F; exp_dp_n = 1'b1; exp_fs = 1'b0;
        end else begin
            m++;
            n     = m - 1;
            presc = n % RD;
            d     = ND - 1 - ((n / RD) % ND);
            exp_fs = (m == 1) || (m % FRAME == 0);
            if (presc < DC) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_seg_h0 = 7'h7F; exp_dp_n = 1'b1;
            end else begin
                dark = snap_lzb && (d != 0) && ((snap_val >> (4 * d)) == 16'h0);
                exp_an = blank ? 4'hF : ~(4'b0001 << d);
                exp_seg    = dark ? 7'h7F : dec(snap_val[4*d +: 4], 1'b1);
                exp_seg_h0 = dark ? 7'h7F : dec(snap_val[4*d +: 4], 1'b0);
                exp_dp_n   = dark ? 1'b1 : ~snap_dp[d];
            end
            if (m == 1 || m % FRAME == 0) begin
                snap_val = value; snap_dp = dp; snap_lzb = lzb;
            end
        end
        @(negedge clk);
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("seg_hex0", 32'(seg_h0), 32'(exp_seg_h0));
        chk("dp_n", 32'(dp_n), 32'(exp_dp_n));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        rst = 1'b0; value = 16'h1234; dp = 4'h0; lzb = 1'b0; blank = 1'b0;

        // Reset held for 3 cycles, then a full scan of 1234.
        run(3);
        rst = 1'b1;
        run(2 * FRAME);

        // Leading-zero blanking with decimal points on the blanked digits.
        value = 16'h0050; dp = 4'b1100; lzb = 1'b1;
        run(2 * FRAME);

        // Frame coherence: change the value during digit 2's slot.
        value = 16'h1111; dp = 4'h0; lzb = 1'b0;
        for (int i = 0; i < 3 * FRAME && (m % FRAME) != 11; i++) tick();
        value = 16'h2222;
        run(2 * FRAME);

        // Hex codes on both decode modes, with blank asserted mid-slot.
        value = 16'hAF09;
        run(FRAME + 4);
        blank = 1'b1;
        run(FRAME);
        blank = 1'b0;
        run(8);

        // Randomised inputs with sporadic blanking.
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 9) == 0) value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 19) == 0) lzb = ~lzb;
            if ($urandom_range(0, 9) == 0) blank = ~blank;
            tick();
        end
        blank = 1'b0;
        value = 16'h5678;

        // Reset asserted at prescaler 5 of digit 1; scanning must restart at digit 3.
        for (int i = 0; i < 3 * FRAME && !((m % RD) == 5 && ((m / RD) % ND) == 2); i++) tick();
        chk("reached_mid_slot", 32'(m % RD), 32'd5);
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
